// File: rtl/led_sequencer.sv
// led_sequencer
//   Steps an LED pattern at a fixed rate. A debounced pushbutton cycles the
//   pattern mode through ROT_L, ROT_R, BOUNCE, BLINK and COUNT.
//
// Parameters
//   NUM_LEDS   : LED count (2..32)
//   CLK_HZ     : sys_clk frequency in Hz
//   STEP_MS    : pattern step period in ms
//   DEB_MS     : button debounce time in ms
//   ACTIVE_LOW : 1 = LED outputs are driven inverted
//
// Ports
//   sys_clk    : clock, all state on the rising edge
//   sys_rst_n  : asynchronous active-low reset
//   mode_btn_n : raw asynchronous pushbutton, 0 = pressed
//   run        : 1 = advance the pattern, 0 = freeze pattern and prescaler
//   led        : registered LED drive
//   mode       : current mode code (0..4)
//   step_tick  : one-cycle pulse in the cycle that ends a pattern step
module led_sequencer #(
  parameter int NUM_LEDS   = 6,
  parameter int CLK_HZ     = 27_000_000,
  parameter int STEP_MS    = 500,
  parameter int DEB_MS     = 20,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                mode_btn_n,
  input  logic                run,
  output logic [NUM_LEDS-1:0] led,
  output logic [2:0]          mode,
  output logic                step_tick
);

  localparam int unsigned STEP_CYC = CLK_HZ / 1000 * STEP_MS;
  localparam int unsigned DEB_CYC  = CLK_HZ / 1000 * DEB_MS;
  localparam int SW = (STEP_CYC > 32'd1) ? $clog2(STEP_CYC) : 1;
  localparam int DW = (DEB_CYC > 32'd1) ? $clog2(DEB_CYC) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 32'd1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 32'd1);
  localparam logic [SW-1:0] STEP_ZERO = {SW{1'b0}};
  localparam logic [DW-1:0] DEB_ZERO  = {DW{1'b0}};

  localparam logic [NUM_LEDS-1:0] P_ZERO  = {NUM_LEDS{1'b0}};
  localparam logic [NUM_LEDS-1:0] P_ONE   = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0] LED_RST = ACTIVE_LOW ? ~P_ONE : P_ONE;

  typedef enum logic [2:0] {
    MODE_ROT_L  = 3'd0,
    MODE_ROT_R  = 3'd1,
    MODE_BOUNCE = 3'd2,
    MODE_BLINK  = 3'd3,
    MODE_COUNT  = 3'd4
  } mode_e;

  // Button synchroniser and debouncer
  logic          sync1_r;
  logic          sync2_r;
  logic          deb_pressed_r;
  logic          deb_pressed_nxt_s;
  logic [DW-1:0] deb_cnt_r;
  logic [DW-1:0] deb_cnt_nxt_s;
  logic          deb_mismatch_s;
  logic          deb_flip_s;
  logic          press_s;

  // Step prescaler
  logic [SW-1:0] pre_cnt_r;
  logic [SW-1:0] pre_nxt_s;
  logic          tick_s;

  // Mode and pattern state
  mode_e               mode_r;
  mode_e               mode_nxt_s;
  logic [NUM_LEDS-1:0] p_r;
  logic [NUM_LEDS-1:0] p_nxt_s;
  logic                dir_left_r;
  logic                dir_left_nxt_s;
  logic [NUM_LEDS-1:0] led_r;

  // Two-flop synchroniser for the raw button, idling at "released"
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= mode_btn_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounced state flips on the DEB_CYC-th consecutive mismatching cycle;
  // a single agreeing cycle restarts the count.
  assign deb_mismatch_s = (~sync2_r) != deb_pressed_r;
  assign deb_flip_s     = deb_mismatch_s && (deb_cnt_r == DEB_LAST);
  assign press_s        = deb_flip_s && !deb_pressed_r;

  // Debounce counter and debounced state next-value logic
  always_comb begin
    deb_cnt_nxt_s     = deb_cnt_r;
    deb_pressed_nxt_s = deb_pressed_r;
    if (deb_flip_s) begin
      deb_cnt_nxt_s     = DEB_ZERO;
      deb_pressed_nxt_s = ~deb_pressed_r;
    end else if (deb_mismatch_s) begin
      deb_cnt_nxt_s     = deb_cnt_r + DW'(1'b1);
    end else begin
      deb_cnt_nxt_s     = DEB_ZERO;
    end
  end

  // Debounce state registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      deb_cnt_r     <= DEB_ZERO;
      deb_pressed_r <= 1'b0;
    end else begin
      deb_cnt_r     <= deb_cnt_nxt_s;
      deb_pressed_r <= deb_pressed_nxt_s;
    end
  end

  // The tick is a decode of the held count, so it drops as soon as run drops.
  assign tick_s = run && (pre_cnt_r == STEP_LAST);

  // Prescaler next value: a press restarts the step period
  always_comb begin
    pre_nxt_s = pre_cnt_r;
    if (press_s) begin
      pre_nxt_s = STEP_ZERO;
    end else if (tick_s) begin
      pre_nxt_s = STEP_ZERO;
    end else if (run) begin
      pre_nxt_s = pre_cnt_r + SW'(1'b1);
    end else begin
      pre_nxt_s = pre_cnt_r;
    end
  end

  // Prescaler register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_cnt_r <= STEP_ZERO;
    end else begin
      pre_cnt_r <= pre_nxt_s;
    end
  end

  // Mode/pattern next-state: a press takes priority over a coincident tick
  always_comb begin
    mode_nxt_s     = mode_r;
    p_nxt_s        = p_r;
    dir_left_nxt_s = dir_left_r;
    if (press_s) begin
      case (mode_r)
        MODE_ROT_L:  mode_nxt_s = MODE_ROT_R;
        MODE_ROT_R:  mode_nxt_s = MODE_BOUNCE;
        MODE_BOUNCE: mode_nxt_s = MODE_BLINK;
        MODE_BLINK:  mode_nxt_s = MODE_COUNT;
        MODE_COUNT:  mode_nxt_s = MODE_ROT_L;
        default:     mode_nxt_s = MODE_ROT_L;
      endcase
      dir_left_nxt_s = 1'b1;
      if ((mode_nxt_s == MODE_BLINK) || (mode_nxt_s == MODE_COUNT)) begin
        p_nxt_s = P_ZERO;
      end else begin
        p_nxt_s = P_ONE;
      end
    end else if (tick_s) begin
      case (mode_r)
        MODE_ROT_L:  p_nxt_s = {p_r[NUM_LEDS-2:0], p_r[NUM_LEDS-1]};
        MODE_ROT_R:  p_nxt_s = {p_r[0], p_r[NUM_LEDS-1:1]};
        MODE_BOUNCE: begin
          // Turn around while sitting on an end bit so each end shows once.
          if (dir_left_r && p_r[NUM_LEDS-1]) begin
            p_nxt_s        = {1'b0, p_r[NUM_LEDS-1:1]};
            dir_left_nxt_s = 1'b0;
          end else if (dir_left_r) begin
            p_nxt_s        = {p_r[NUM_LEDS-2:0], 1'b0};
          end else if (p_r[0]) begin
            p_nxt_s        = {p_r[NUM_LEDS-2:0], 1'b0};
            dir_left_nxt_s = 1'b1;
          end else begin
            p_nxt_s        = {1'b0, p_r[NUM_LEDS-1:1]};
          end
        end
        MODE_BLINK:  p_nxt_s = ~p_r;
        MODE_COUNT:  p_nxt_s = p_r + P_ONE;
        default: begin
          // Unreachable codes recover to the reset mode.
          mode_nxt_s     = MODE_ROT_L;
          p_nxt_s        = P_ONE;
          dir_left_nxt_s = 1'b1;
        end
      endcase
    end else begin
      p_nxt_s = p_r;
    end
  end

  // Mode/pattern state register; LED drive is registered from the next pattern
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_r     <= MODE_ROT_L;
      p_r        <= P_ONE;
      dir_left_r <= 1'b1;
      led_r      <= LED_RST;
    end else begin
      mode_r     <= mode_nxt_s;
      p_r        <= p_nxt_s;
      dir_left_r <= dir_left_nxt_s;
      led_r      <= ACTIVE_LOW ? ~p_nxt_s : p_nxt_s;
    end
  end

  assign led       = led_r;
  assign mode      = mode_r;
  assign step_tick = tick_s;

endmodule
